fp_mul_pipe: RTL and testbench
==============================

# fp_mul_pipe

Parametrised, pipelined IEEE-754 binary floating-point multiplier with a valid/ready handshake, a pass-through tag and round-to-nearest-even. It supersedes the combinational `fp_mul` (`IN1`/`IN2`/`OUT`) in datapaths that need configurable formats, registered timing and backpressure. It accepts one operation per cycle with a fixed 3-cycle latency.

## Interface
- `EXP_W`, default 8: exponent width; bias = 2^(EXP_W-1)-1.
- `MAN_W`, default 23: stored mantissa width, hidden bit excluded.
- `TAG_W`, default 4: width of the user tag carried alongside each operation.
- `clk`  in  1  clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  an operation is presented on `IN1`, `IN2` and `in_tag`.
- `in_ready`  out  1  the block can accept an operation this cycle.
- `IN1`, `IN2`  in  1+EXP_W+MAN_W  operands, packed as {sign, exp, man}.
- `in_tag`  in  TAG_W  user tag.
- `out_valid`  out  1  `OUT`, `out_tag` and `flags` hold a result.
- `out_ready`  in  1  the consumer accepts the result this cycle.
- `OUT`  out  1+EXP_W+MAN_W  product.
- `out_tag`  out  TAG_W  the tag of the operation that produced `OUT`.
- `flags`  out  4  {invalid, overflow, underflow, inexact}; present only under `FP_MUL_FLAGS_EN`.

## Operation
- Transfer rules:
  - Input transfer: `in_valid && in_ready` at a rising edge.
  - Output transfer: `out_valid && out_ready` at a rising edge.
- Three register stages, each with its own valid bit `v1`, `v2`, `v3`. `v3` drives `out_valid`.
  - S1: unpack and classify operands, xor the signs, form the exponent sum, form the (MAN_W+1)x(MAN_W+1) significand product.
  - S2: normalise, round and detect overflow/underflow.
  - S3: pack the result and hold the output registers.
- Stage advance:
  - `ready3 = out_ready`; `ready_k = !v_k || ready_{k+1}`; `in_ready = ready1`.
  - The `ready` path is combinational from `out_ready`.
  - A stage with valid set and no ready holds its contents.
- Exponent arithmetic:
  - Signed, EXP_W+2 bits wide.
  - `e = ea + eb - bias`.
  - If the product MSB is set, shift the product right by 1 and increment `e`.
- Rounding is RNE on {guard, sticky}; sticky is the OR of all lower product bits.
  - A mantissa carry-out after rounding renormalises the mantissa to 1.0 and increments `e`.
  - Overflow and underflow checks use the post-rounding `e`.
- Special cases, in priority order:
  1. Any NaN input, or inf × zero → canonical qNaN (sign 0, exp all ones, man MSB 1, rest 0). inf × zero also sets invalid.
  2. inf × nonzero → inf, signed by xor of the input signs.
  3. zero × finite → zero, signed by xor of the input signs.
  4. `e >= 2^EXP_W-1` → signed inf; sets overflow and inexact.
  5. `e <= 0` → signed zero; sets underflow and inexact (flush-to-zero).
- Subnormal inputs (exp 0, man ≠ 0) are treated as signed zero and raise no flag.
- Inexact is set whenever guard or sticky is nonzero on a finite result.
- `in_tag` travels unchanged with its operation. Results leave in acceptance order.

## Timing
- Reset values:
  - While `rst` is high: `v1`, `v2`, `v3` = 0, `out_valid` = 0, `OUT` = 0, `out_tag` = 0, `flags` = 0, `in_ready` = 0.
  - `in_ready` = 1 from the first cycle after `rst` deasserts.
- Latency: an operation accepted at edge N has `out_valid` = 1 during cycle N+3, provided no stall occurs.
- Throughput: 1 op/cycle while `out_ready` = 1.
- With `out_ready` held low, at most 3 operations are accepted. `in_ready` then drops combinationally.
- While `out_valid && !out_ready`, `OUT`, `out_tag` and `flags` are stable.
- On a full pipeline with `out_ready` = 1, an output and an input transfer happen in the same cycle, with no bubble.
- `rst` asserted mid-operation discards every in-flight operation immediately. No partial result appears afterwards.
- `in_valid` while `in_ready` = 0 is ignored, and the operands are not sampled.

## Configuration
- `FP_MUL_FLAGS_EN`:
  - Defined: the `flags` port exists, and flag bits are computed and registered through S1–S3.
  - Undefined: the `flags` port and all flag logic are absent. `OUT`, timing and handshake are identical in both builds.

## Test plan
- Default params, `out_ready` = 1:
  - 0x3FC00000 × 0x3FC00000 → 0x40100000, flags 0000, 3 cycles after acceptance.
  - 0xBF91EB85 × 0x75CABCBD → 0xF5E71ED7, inexact set.
- Special cases:
  - 0x7F800000 × 0x00000000 → 0x7FC00000, invalid set.
  - 0xFF800000 × 0x40000000 → 0xFF800000, flags 0000.
  - 0x7F000000 × 0x7F000000 → 0x7F800000, overflow and inexact set.
  - 0x00800000 × 0x00800000 → 0x00000000, underflow and inexact set.
- Backpressure: stream tags 1..6 with `out_ready` low for 6 cycles, then high → `in_ready` drops after 3 acceptances; outputs arrive as tags 1..6 in order, none lost or duplicated; `OUT` stable while stalled.
- Back-to-back: 8 consecutive ops with `out_ready` = 1 → 8 consecutive `out_valid` cycles; first result 3 cycles after the first acceptance.
- Reset mid-flight: accept 2 ops, pulse `rst` asynchronously between edges → `out_valid` = 0 immediately and no stale result ever emerges; a new op afterwards returns after 3 cycles.
- Format: `EXP_W`=5, `MAN_W`=10 (binary16): 0x3E00 × 0x3E00 → 0x4080; 0x7BFF × 0x4000 → 0x7C00 with overflow set.

Source files
------------

// File: rtl/fp_mul_pipe.sv
// fp_mul_pipe: three-stage pipelined IEEE-754 multiplier with a valid/ready
// handshake, a pass-through tag, round-to-nearest-even and flush-to-zero.
// Stage 1 classifies the operands and forms the exponent sum and the significand product.
// Stage 2 normalises and rounds, and resolves the special cases.
// Stage 3 packs the result and holds it until the consumer accepts it.
// Optional feature macro: FP_MUL_FLAGS_EN adds the 4-bit flags output
// {invalid, overflow, underflow, inexact} and the logic that computes it.
module fp_mul_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int TAG_W = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   IN1,
    input  logic [EXP_W+MAN_W:0]   IN2,
    input  logic [TAG_W-1:0]       in_tag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   OUT,
`ifdef FP_MUL_FLAGS_EN
    output logic [3:0]             flags,
`endif
    output logic [TAG_W-1:0]       out_tag
);

    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int EW = EXP_W + 2;          // signed working exponent width
    localparam int PW = 2 * MAN_W + 2;      // full significand product width

    localparam logic signed [EW-1:0] BIAS_S = EW'((1 << (EXP_W - 1)) - 1);
    localparam logic signed [EW-1:0] EMAX_S = EW'((1 << EXP_W) - 1);
    localparam logic signed [EW-1:0] ZERO_S = '0;
    localparam logic signed [EW-1:0] ONE_S  = EW'(1);
    localparam logic [EXP_W-1:0]     EXP_ONES = '1;
    localparam logic [MAN_W-1:0]     QNAN_MAN = {1'b1, {(MAN_W-1){1'b0}}};

    // Operation class decided in stage 1, consumed in stage 2
    localparam logic [1:0] K_NUM  = 2'd0;
    localparam logic [1:0] K_NAN  = 2'd1;
    localparam logic [1:0] K_INF  = 2'd2;
    localparam logic [1:0] K_ZERO = 2'd3;

    // ------------------------------------------------------------------
    // Handshake: each stage may load when it is empty or its successor
    // loads in the same cycle, so a full pipe still streams without bubbles.
    // ------------------------------------------------------------------
    logic v1, v2, v3;
    logic load1, load2, load3;

    assign load3     = !v3 || out_ready;
    assign load2     = !v2 || load3;
    assign load1     = !v1 || load2;
    assign in_ready  = load1 && !rst;
    assign out_valid = v3;

    // ------------------------------------------------------------------
    // Stage 1: unpack and classify both operands
    // ------------------------------------------------------------------
    logic [W-1:0]     op [2];
    logic [EXP_W-1:0] op_exp [2];
    logic [MAN_W-1:0] op_man [2];
    logic [1:0]       op_sign, op_nan, op_inf, op_zero;

    assign op[0] = IN1;
    assign op[1] = IN2;

    for (genvar gi = 0; gi < 2; gi++) begin : g_unpack
        assign op_sign[gi] = op[gi][W-1];
        assign op_exp[gi]  = op[gi][W-2 -: EXP_W];
        assign op_man[gi]  = op[gi][MAN_W-1:0];
        assign op_nan[gi]  = (op_exp[gi] == EXP_ONES) && (op_man[gi] != '0);
        assign op_inf[gi]  = (op_exp[gi] == EXP_ONES) && (op_man[gi] == '0);
        // Subnormals are flushed: exponent 0 counts as zero whatever the mantissa
        assign op_zero[gi] = (op_exp[gi] == '0);
    end

    logic                 inf_zero;
    logic [1:0]           s1_kind_next;
    logic signed [EW-1:0] s1_exp_next;
    logic [PW-1:0]        s1_prod_next;

    assign inf_zero     = (op_inf[0] && op_zero[1]) || (op_inf[1] && op_zero[0]);
    assign s1_exp_next  = $signed({2'b00, op_exp[0]}) + $signed({2'b00, op_exp[1]}) - BIAS_S;
    assign s1_prod_next = PW'({1'b1, op_man[0]}) * PW'({1'b1, op_man[1]});

    // Special-case priority: NaN / inf*zero, then infinity, then zero
    always_comb begin
        s1_kind_next = K_NUM;
        if ((|op_nan) || inf_zero) begin
            s1_kind_next = K_NAN;
        end else if (|op_inf) begin
            s1_kind_next = K_INF;
        end else if (|op_zero) begin
            s1_kind_next = K_ZERO;
        end
    end

    logic                 s1_sign;
    logic [1:0]           s1_kind;
    logic signed [EW-1:0] s1_exp;
    logic [PW-1:0]        s1_prod;
    logic [TAG_W-1:0]     s1_tag;
`ifdef FP_MUL_FLAGS_EN
    logic                 s1_invalid;
`endif

    // Stage 1 register: capture a new operation only on an input transfer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1      <= 1'b0;
            s1_sign <= 1'b0;
            s1_kind <= K_NUM;
            s1_exp  <= '0;
            s1_prod <= '0;
            s1_tag  <= '0;
`ifdef FP_MUL_FLAGS_EN
            s1_invalid <= 1'b0;
`endif
        end else if (load1) begin
            v1 <= in_valid;
            if (in_valid) begin
                s1_sign <= op_sign[0] ^ op_sign[1];
                s1_kind <= s1_kind_next;
                s1_exp  <= s1_exp_next;
                s1_prod <= s1_prod_next;
                s1_tag  <= in_tag;
`ifdef FP_MUL_FLAGS_EN
                s1_invalid <= inf_zero;
`endif
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: normalise, round to nearest even, range check
    // ------------------------------------------------------------------
    logic signed [EW-1:0] norm_exp, rnd_exp;
    logic [MAN_W-1:0]     norm_man, rnd_man;
    logic [MAN_W:0]       man_sum;
    logic                 guard, sticky, round_up, ovf, unf;

    // Pick the fraction, guard and sticky bits on either side of the product MSB
    always_comb begin
        norm_exp = s1_exp;
        norm_man = s1_prod[PW-3 -: MAN_W];
        guard    = s1_prod[MAN_W-1];
        sticky   = |s1_prod[MAN_W-2:0];
        if (s1_prod[PW-1]) begin
            norm_exp = s1_exp + ONE_S;
            norm_man = s1_prod[PW-2 -: MAN_W];
            guard    = s1_prod[MAN_W];
            sticky   = |s1_prod[MAN_W-1:0];
        end
    end

    // A carry out of the fraction means the significand rounded up to 2.0:
    // the fraction bits are already zero, so only the exponent moves.
    assign round_up = guard && (sticky || norm_man[0]);
    assign man_sum  = {1'b0, norm_man} + (MAN_W+1)'(round_up);
    assign rnd_man  = man_sum[MAN_W-1:0];
    assign rnd_exp  = norm_exp + EW'(man_sum[MAN_W]);
    assign ovf      = rnd_exp >= EMAX_S;
    assign unf      = rnd_exp <= ZERO_S;

    logic             res_sign;
    logic [EXP_W-1:0] res_exp;
    logic [MAN_W-1:0] res_man;
`ifdef FP_MUL_FLAGS_EN
    logic [3:0]       res_flags;
`endif

    // Resolve the final sign/exponent/fraction and flags for each class
    always_comb begin
        res_sign = s1_sign;
        res_exp  = rnd_exp[EXP_W-1:0];
        res_man  = rnd_man;
`ifdef FP_MUL_FLAGS_EN
        res_flags = 4'b0000;
`endif
        case (s1_kind)
            K_NAN: begin
                res_sign = 1'b0;
                res_exp  = EXP_ONES;
                res_man  = QNAN_MAN;
`ifdef FP_MUL_FLAGS_EN
                res_flags = {s1_invalid, 3'b000};
`endif
            end
            K_INF: begin
                res_exp = EXP_ONES;
                res_man = '0;
            end
            K_ZERO: begin
                res_exp = '0;
                res_man = '0;
            end
            default: begin
                if (ovf) begin
                    res_exp = EXP_ONES;
                    res_man = '0;
`ifdef FP_MUL_FLAGS_EN
                    res_flags = 4'b0101;
`endif
                end else if (unf) begin
                    res_exp = '0;
                    res_man = '0;
`ifdef FP_MUL_FLAGS_EN
                    res_flags = 4'b0011;
`endif
                end else begin
`ifdef FP_MUL_FLAGS_EN
                    res_flags = {3'b000, guard | sticky};
`endif
                end
            end
        endcase
    end

    logic             s2_sign;
    logic [EXP_W-1:0] s2_exp;
    logic [MAN_W-1:0] s2_man;
    logic [TAG_W-1:0] s2_tag;
`ifdef FP_MUL_FLAGS_EN
    logic [3:0]       s2_flags;
`endif

    // Stage 2 register: advance when stage 3 can take the current contents
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2      <= 1'b0;
            s2_sign <= 1'b0;
            s2_exp  <= '0;
            s2_man  <= '0;
            s2_tag  <= '0;
`ifdef FP_MUL_FLAGS_EN
            s2_flags <= 4'b0000;
`endif
        end else if (load2) begin
            v2 <= v1;
            if (v1) begin
                s2_sign <= res_sign;
                s2_exp  <= res_exp;
                s2_man  <= res_man;
                s2_tag  <= s1_tag;
`ifdef FP_MUL_FLAGS_EN
                s2_flags <= res_flags;
`endif
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 3: pack and hold; contents freeze while the consumer stalls
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v3      <= 1'b0;
            OUT     <= '0;
            out_tag <= '0;
`ifdef FP_MUL_FLAGS_EN
            flags   <= 4'b0000;
`endif
        end else if (load3) begin
            v3 <= v2;
            if (v2) begin
                OUT     <= {s2_sign, s2_exp, s2_man};
                out_tag <= s2_tag;
`ifdef FP_MUL_FLAGS_EN
                flags   <= s2_flags;
`endif
            end
        end
    end

endmodule

// File: tb/tb_fp_mul_pipe.sv
// tb_fp_mul_pipe: scoreboard bench for fp_mul_pipe. Expected results come
// from a value-level reference multiplier (integer significand product,
// remainder-based nearest-even rounding); monitors compare on each output transfer.
`timescale 1ns/1ps
module tb_fp_mul_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;

    logic        iv32, ir32, ov32, or32;
    logic [31:0] a32, b32, y32;
    logic [3:0]  it32, ot32;
    logic        iv16, ir16, ov16, or16;
    logic [15:0] a16, b16, y16;
    logic [3:0]  it16, ot16;
`ifdef FP_MUL_FLAGS_EN
    logic [3:0]  fl32, fl16;
`endif

    fp_mul_pipe u32 (
        .clk(clk), .rst(rst),
        .in_valid(iv32), .in_ready(ir32), .IN1(a32), .IN2(b32), .in_tag(it32),
        .out_valid(ov32), .out_ready(or32), .OUT(y32),
`ifdef FP_MUL_FLAGS_EN
        .flags(fl32),
`endif
        .out_tag(ot32)
    );

    fp_mul_pipe #(.EXP_W(5), .MAN_W(10), .TAG_W(4)) u16 (
        .clk(clk), .rst(rst),
        .in_valid(iv16), .in_ready(ir16), .IN1(a16), .IN2(b16), .in_tag(it16),
        .out_valid(ov16), .out_ready(or16), .OUT(y16),
`ifdef FP_MUL_FLAGS_EN
        .flags(fl16),
`endif
        .out_tag(ot16)
    );

    typedef struct {
        logic [31:0] res;
        logic [3:0]  fl;
        logic [3:0]  tag;
        int          acc;
        bit          lat;
    } exp_t;

    exp_t sb32[$];
    exp_t sb16[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   accepts = 0;
    bit   bp_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s got=%h required=%h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference multiply on values: returns {flags, result}
    function automatic logic [35:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                            input int E, input int M);
        longint unsigned mask, ma, mb, pr, q, r, half_v, res, sgn, qnan;
        int ea, eb, emax, bias, e, lead, sh;
        bit s, nan_a, nan_b, inf_a, inf_b, z_a, z_b;
        logic [3:0] fl;
        emax = (1 << E) - 1;
        bias = (1 << (E - 1)) - 1;
        mask = (64'd1 << M) - 1;
        ma = a & mask;
        mb = b & mask;
        ea = int'((a >> M) & 32'(emax));
        eb = int'((b >> M) & 32'(emax));
        s  = a[E+M] ^ b[E+M];
        sgn = longint'(s) << (E + M);
        qnan = (longint'(emax) << M) | (64'd1 << (M - 1));
        nan_a = (ea == emax) && (ma != 0);
        nan_b = (eb == emax) && (mb != 0);
        inf_a = (ea == emax) && (ma == 0);
        inf_b = (eb == emax) && (mb == 0);
        z_a = (ea == 0);
        z_b = (eb == 0);
        fl = 4'b0000;
        if (nan_a || nan_b || (inf_a && z_b) || (inf_b && z_a)) begin
            res = qnan;
            if ((inf_a && z_b) || (inf_b && z_a)) fl = 4'b1000;
        end else if (inf_a || inf_b) begin
            res = sgn | (longint'(emax) << M);
        end else if (z_a || z_b) begin
            res = sgn;
        end else begin
            pr = ((64'd1 << M) | ma) * ((64'd1 << M) | mb);
            lead = (((pr >> (2 * M + 1)) & 64'd1) != 0) ? 2 * M + 1 : 2 * M;
            sh = lead - M;
            q = pr >> sh;
            r = pr & ((64'd1 << sh) - 1);
            half_v = 64'd1 << (sh - 1);
            if (r > half_v || (r == half_v && q[0])) q = q + 1;
            e = ea + eb - bias + (lead - 2 * M);
            if ((q >> (M + 1)) != 0) begin
                q = q >> 1;
                e = e + 1;
            end
            if (e >= emax) begin
                res = sgn | (longint'(emax) << M);
                fl = 4'b0101;
            end else if (e <= 0) begin
                res = sgn;
                fl = 4'b0011;
            end else begin
                res = sgn | (longint'(e) << M) | (q & mask);
                fl = {3'b000, r != 0};
            end
        end
        return {fl, res[31:0]};
    endfunction

    // Operand generator biased toward specials and exponent boundaries
    function automatic logic [31:0] rnd_op(input int E, input int M);
        int emax, bias, e, sel;
        logic [31:0] mask, man;
        emax = (1 << E) - 1;
        bias = (1 << (E - 1)) - 1;
        mask = (32'd1 << M) - 1;
        sel = int'($urandom_range(0, 9));
        case (sel)
            0: e = 0;
            1: e = emax;
            2: e = int'($urandom_range(1, 3));
            3: e = emax - int'($urandom_range(1, 3));
            4: e = bias / 2 + int'($urandom_range(0, 3));
            5: e = (3 * bias) / 2 + int'($urandom_range(0, 3));
            default: e = int'($urandom_range(bias / 2, bias + bias / 2));
        endcase
        sel = int'($urandom_range(0, 5));
        man = (sel == 0) ? 32'd0 : (sel == 1) ? mask : ($urandom & mask);
        return (32'($urandom_range(0, 1)) << (E + M)) | (32'(e) << M) | man;
    endfunction

    task automatic send(input bit half, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] t, input logic [31:0] er, input logic [3:0] ef,
                        input bit lat);
        exp_t e;
        int n;
        if (half) begin iv16 = 1'b1; a16 = a[15:0]; b16 = b[15:0]; it16 = t; end
        else begin iv32 = 1'b1; a32 = a; b32 = b; it32 = t; end
        n = 0;
        @(negedge clk);
        while ((half ? ir16 : ir32) !== 1'b1 && n <= 200) begin
            n++;
            @(negedge clk);
        end
        if (n > 200) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout tag=%0d in_ready=0 required=1", t);
        end else begin
            e.res = er; e.fl = ef; e.tag = t; e.acc = cyc + 1; e.lat = lat;
            if (half) sb16.push_back(e); else sb32.push_back(e);
            accepts++;
        end
        @(posedge clk);
        #1;
        if (half) iv16 = 1'b0; else iv32 = 1'b0;
    endtask

    task automatic send_rand(input bit half, input logic [3:0] t, input bit lat);
        logic [31:0] a, b;
        logic [35:0] m;
        a = half ? rnd_op(5, 10) : rnd_op(8, 23);
        b = half ? rnd_op(5, 10) : rnd_op(8, 23);
        m = half ? ref_mul(a, b, 5, 10) : ref_mul(a, b, 8, 23);
        send(half, a, b, t, m[31:0], m[35:32], lat);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb32.size() != 0 || sb16.size() != 0) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("drain_pending", 32'(sb32.size() + sb16.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    // Monitor for the binary32 instance: hold check while stalled, pop on transfer
    exp_t        m32_e;
    logic [31:0] hold_y;
    logic [3:0]  hold_t;
    bit          held = 1'b0;
    always @(negedge clk) begin
        if (rst || ov32 !== 1'b1) begin
            held = 1'b0;
        end else begin
            if (held) begin
                check("stall_hold_out", y32, hold_y);
                check("stall_hold_tag", 32'(ot32), 32'(hold_t));
            end
            if (or32 !== 1'b1) begin
                held = 1'b1;
                hold_y = y32;
                hold_t = ot32;
            end else begin
                held = 1'b0;
                if (sb32.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL u32_unexpected_output got=%h tag=%0d required=none", y32, ot32);
                end else begin
                    m32_e = sb32.pop_front();
                    $display("u32 out tag=%0d OUT=%h required=%h", ot32, y32, m32_e.res);
                    check("u32_result", y32, m32_e.res);
                    check("u32_tag", 32'(ot32), 32'(m32_e.tag));
`ifdef FP_MUL_FLAGS_EN
                    check("u32_flags", 32'(fl32), 32'(m32_e.fl));
`endif
                    if (m32_e.lat) check("u32_latency", 32'(cyc - m32_e.acc + 1), 32'd3);
                end
            end
        end
    end

    // Monitor for the binary16 instance (never stalled)
    exp_t m16_e;
    always @(negedge clk) begin
        if (!rst && ov16 === 1'b1 && or16 === 1'b1) begin
            if (sb16.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL u16_unexpected_output got=%h tag=%0d required=none", y16, ot16);
            end else begin
                m16_e = sb16.pop_front();
                $display("u16 out tag=%0d OUT=%h required=%h", ot16, y16, m16_e.res[15:0]);
                check("u16_result", 32'(y16), 32'(m16_e.res[15:0]));
                check("u16_tag", 32'(ot16), 32'(m16_e.tag));
`ifdef FP_MUL_FLAGS_EN
                check("u16_flags", 32'(fl16), 32'(m16_e.fl));
`endif
                if (m16_e.lat) check("u16_latency", 32'(cyc - m16_e.acc + 1), 32'd3);
            end
        end
    end

    // Random consumer backpressure for the binary32 instance
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (bp_en) or32 = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    logic [31:0] d_a [6] = '{32'h3FC00000, 32'hBF91EB85, 32'h7F800000,
                             32'hFF800000, 32'h7F000000, 32'h00800000};
    logic [31:0] d_b [6] = '{32'h3FC00000, 32'h75CABCBD, 32'h00000000,
                             32'h40000000, 32'h7F000000, 32'h00800000};
    logic [31:0] d_y [6] = '{32'h40100000, 32'hF5E71ED7, 32'h7FC00000,
                             32'hFF800000, 32'h7F800000, 32'h00000000};
    logic [3:0]  d_f [6] = '{4'b0000, 4'b0001, 4'b1000, 4'b0000, 4'b0101, 4'b0011};

    initial begin
        int base;
        iv32 = 1'b0; iv16 = 1'b0; or32 = 1'b1; or16 = 1'b1;
        a32 = '0; b32 = '0; it32 = '0; a16 = '0; b16 = '0; it16 = '0;

        // Reset state
        #12;
        check("rst_out_valid", 32'(ov32), 32'd0);
        check("rst_in_ready", 32'(ir32), 32'd0);
        check("rst_out", y32, 32'd0);
        check("rst_out_tag", 32'(ot32), 32'd0);
        check("rst_in_ready16", 32'(ir16), 32'd0);
`ifdef FP_MUL_FLAGS_EN
        check("rst_flags", 32'(fl32), 32'd0);
`endif
        @(posedge clk);
        #3 rst = 1'b0;
        @(negedge clk);
        check("in_ready_after_reset", 32'(ir32), 32'd1);
        @(posedge clk);
        #1;

        // Directed vectors, both formats, with latency checks
        for (int i = 0; i < 6; i++) send(1'b0, d_a[i], d_b[i], 4'(i + 1), d_y[i], d_f[i], 1'b1);
        send(1'b1, 32'h3E00, 32'h3E00, 4'd7, 32'h4080, 4'b0000, 1'b1);
        send(1'b1, 32'h7BFF, 32'h4000, 4'd8, 32'h7C00, 4'b0101, 1'b1);
        drain();

        // Back-to-back stream of 8
        for (int i = 0; i < 8; i++) send_rand(1'b0, 4'(i), 1'b1);
        drain();

        // Backpressure: six tags with the consumer stalled for six cycles
        base = accepts;
        or32 = 1'b0;
        fork
            begin
                for (int t = 1; t <= 6; t++) send_rand(1'b0, 4'(t), 1'b0);
            end
            begin
                repeat (6) @(posedge clk);
                @(negedge clk);
                check("accepted_while_stalled", 32'(accepts - base), 32'd3);
                check("in_ready_while_full", 32'(ir32), 32'd0);
                @(posedge clk);
                #1 or32 = 1'b1;
            end
        join
        drain();

        // Reset while two operations are in flight
        send_rand(1'b0, 4'd9, 1'b0);
        send_rand(1'b0, 4'd10, 1'b0);
        @(posedge clk);
        #3;
        check("valid_before_reset", 32'(ov32), 32'd1);
        rst = 1'b1;
        #1;
        check("midrst_out_valid", 32'(ov32), 32'd0);
        check("midrst_in_ready", 32'(ir32), 32'd0);
        check("midrst_out", y32, 32'd0);
        check("midrst_out_tag", 32'(ot32), 32'd0);
        sb32.delete();
        @(posedge clk);
        #3 rst = 1'b0;
        repeat (6) begin
            @(negedge clk);
            check("no_stale_output", 32'(ov32), 32'd0);
        end
        @(posedge clk);
        #1;
        send_rand(1'b0, 4'd11, 1'b1);
        drain();

        // Randomised traffic with random consumer stalls and idle gaps
        bp_en = 1'b1;
        for (int i = 0; i < 250; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
            send_rand(1'b0, 4'($urandom), 1'b0);
        end
        bp_en = 1'b0;
        @(posedge clk);
        #2 or32 = 1'b1;

        // Randomised binary16 traffic
        for (int i = 0; i < 80; i++) send_rand(1'b1, 4'($urandom), 1'b0);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
